// File: rtl/bit_serial_subtractor_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
// The master issues start with operands; the slave returns the result and status.
interface bit_serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  diff, borrow_out, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, borrow_out, busy, done
    );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first,
// using a single full-subtractor cell and a registered borrow.
module bit_serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    bit_serial_subtractor_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             d_bit;
    logic             borrow_nxt;

    // Full-subtractor cell on the current LSBs
    always_comb begin
        d_bit      = sa_q[0] ^ sb_q[0] ^ borrow_q;
        borrow_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        sr_d         = sr_q;
        count_d      = count_q;
        borrow_d     = borrow_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d     = bus.a;
                    sb_d     = bus.b;
                    sr_d     = '0;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sa_d     = {1'b0, sa_q[WIDTH-1:1]};
                sb_d     = {1'b0, sb_q[WIDTH-1:1]};
                sr_d     = {d_bit, sr_q[WIDTH-1:1]};
                borrow_d = borrow_nxt;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    diff_d       = {d_bit, sr_q[WIDTH-1:1]};
                    borrow_out_d = borrow_nxt;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            sr_q         <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            sr_q         <= sr_d;
            count_q      <= count_d;
            borrow_q     <= borrow_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: arithmetic reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_bit_serial_subtractor;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;

    bit_serial_subtractor_if #(.WIDTH(W)) bus ();

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_tests = 0;
        n_fail  = 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: an operation takes WIDTH edges, then one done cycle,
    // then the unit is idle again; the result is plain wide subtraction.
    logic [W-1:0] m_diff;
    logic         m_bo;
    logic         m_busy;
    logic         m_done;
    logic [W-1:0] m_res;
    logic         m_bor;
    int           m_left;

    always @(posedge clk or posedge rst) begin
        logic [W:0] full;
        if (rst) begin
            m_diff = '0; m_bo = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_left = 0;  m_res = '0;  m_bor = 1'b0;
            cyc = 0;
        end else begin
            cyc++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_diff = m_res;
                    m_bo   = m_bor;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (bus.start) begin
                full   = {1'b0, bus.a} - {1'b0, bus.b};
                m_res  = full[W-1:0];
                m_bor  = full[W];
                m_left = W;
                m_busy = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("diff",       32'(bus.diff),       32'(m_diff));
        check("borrow_out", 32'(bus.borrow_out), 32'(m_bo));
        check("busy",       32'(bus.busy),       32'(m_busy));
        check("done",       32'(bus.done),       32'(m_done));
    end

    // Launch one operation and wait (bounded) for done; check literals and latency
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input logic exp_bo, input string name);
        int lat;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~a; bus.b = a ^ b;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (bus.done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(W + 1));
        check({name, "_diff"}, 32'(bus.diff), 32'(exp_d));
        check({name, "_borrow"}, 32'(bus.borrow_out), 32'(exp_bo));
    endtask

    task automatic count_done(input int n_cycles, output int n_done);
        n_done = 0;
        for (int i = 0; i < n_cycles; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
    endtask

    initial begin
        int dcount;
        int dcyc[$];
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        @(negedge clk);
        check("reset_diff", 32'(bus.diff), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd100, 8'd37,  8'd63,  1'b0, "100_37");
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        run_op(8'd37,  8'd100, 8'hC1,  1'b1, "37_100");
        run_op(8'h00,  8'h01,  8'hFF,  1'b1, "0_1");
        run_op(8'hFF,  8'hFF,  8'h00,  1'b0, "ff_ff");
        run_op(8'h00,  8'hFF,  8'h01,  1'b1, "0_ff");

        // start during SHIFT with new operands must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h11;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        count_done(W + 4, dcount);
        check("busy_start_done_count", 32'(dcount), 32'd1);
        check("busy_start_diff", 32'(bus.diff), 32'h7F);
        check("busy_start_borrow", 32'(bus.borrow_out), 32'd0);

        // start held high: result every W+2 cycles, operands change each cycle
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 4 * (W + 2) + 2; i++) begin
            bus.a = 8'(8'd17 * i + 3);
            bus.b = 8'(8'd29 * i + 7);
            @(negedge clk);
            if (bus.done) dcyc.push_back(cyc);
        end
        bus.start = 1'b0;
        check("held_done_pulses", 32'(dcyc.size()), 32'd4);
        for (int i = 1; i < dcyc.size(); i++)
            check("held_spacing", 32'(dcyc[i] - dcyc[i-1]), 32'(W + 2));
        repeat (W + 3) @(negedge clk);

        // async reset three cycles into SHIFT
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_diff", 32'(bus.diff), 32'd0);
        check("async_borrow", 32'(bus.borrow_out), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(W + 4, dcount);
        check("no_done_after_reset", 32'(dcount), 32'd0);
        run_op(8'd200, 8'd55, 8'd145, 1'b0, "200_55");
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
